eeprom_ram_bridge: RTL and testbench



---
 rtl/eeprom_ram_bridge.sv | 183 ++++++++++++++++++
 tb/tb_eeprom_ram_bridge.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_ram_bridge.sv
// eeprom_ram_bridge: services the 24C0x model's byte-wide RAM port against the
// shared save-memory bus. It maps EEPROM addresses into the save region, tracks
// dirty state and write count for the flush logic, and times out a silent bus.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for ee_write / ee_read; write wins when both are high
// S_MEM_RD| mem_rd held, waiting for mem_ack or timeout
// S_MEM_WR| mem_wr held, waiting for mem_ack or timeout
// S_DONE  | ee_done held until the serviced strobe drops
module eeprom_ram_bridge #(
   parameter int                ADDR_W  = 18,
   parameter logic [ADDR_W-1:0] BASE    = '0,
   parameter int                TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        size_mask,
   input  logic [7:0]        ee_addr,
   input  logic [7:0]        ee_wdata,
   input  logic              ee_read,
   input  logic              ee_write,
   output logic [7:0]        ee_rdata,
   output logic              ee_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic              dirty,
   input  logic              dirty_clr,
   output logic [15:0]       write_count,
   output logic              timeout_err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_MEM_RD = 2'd1;
   localparam logic [1:0] S_MEM_WR = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // Counter wide enough to hold TIMEOUT; at least one bit so it exists when disabled.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   // The counter starts at 0 on the first request cycle, so the last waiting
   // cycle is TIMEOUT-1; the request is then held for exactly TIMEOUT cycles.
   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   logic [1:0]        state_q, state_d;
   logic              op_wr_q, op_wr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        ee_rdata_q, ee_rdata_d;
   logic              ee_done_q, ee_done_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic              dirty_q, dirty_d;
   logic [15:0]       write_count_q, write_count_d;
   logic              timeout_err_q, timeout_err_d;

   logic [ADDR_W-1:0] mapped_addr;
   logic [15:0]       wc_base;
   logic              timeout_hit;
   logic              strobe_gone;

   // Next-state logic for the access FSM and the dirty / count bookkeeping.
   always_comb begin
      state_d       = state_q;
      op_wr_d       = op_wr_q;
      cnt_d         = cnt_q;
      ee_rdata_d    = ee_rdata_q;
      ee_done_d     = ee_done_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_rd_d      = mem_rd_q;
      mem_wr_d      = mem_wr_q;
      timeout_err_d = timeout_err_q;

      mapped_addr = BASE + ADDR_W'(ee_addr & size_mask);
      timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
      strobe_gone = op_wr_q ? !ee_write : !ee_read;

      // A clear and a write completion in the same cycle: completion wins,
      // leaving dirty set and the count at exactly one.
      wc_base       = dirty_clr ? 16'h0000 : write_count_q;
      dirty_d       = dirty_clr ? 1'b0 : dirty_q;
      write_count_d = wc_base;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (ee_write) begin
               mem_addr_d  = mapped_addr;
               mem_wdata_d = ee_wdata;
               mem_wr_d    = 1'b1;
               op_wr_d     = 1'b1;
               state_d     = S_MEM_WR;
            end else if (ee_read) begin
               mem_addr_d = mapped_addr;
               mem_rd_d   = 1'b1;
               op_wr_d    = 1'b0;
               state_d    = S_MEM_RD;
            end
         end
         S_MEM_RD, S_MEM_WR: begin
            if (mem_ack) begin
               mem_rd_d  = 1'b0;
               mem_wr_d  = 1'b0;
               ee_done_d = 1'b1;
               state_d   = S_DONE;
               if (state_q == S_MEM_RD) begin
                  ee_rdata_d = mem_rdata;
               end else begin
                  dirty_d       = 1'b1;
                  write_count_d = (wc_base == 16'hFFFF) ? wc_base : wc_base + 16'd1;
               end
            end else if (timeout_hit) begin
               mem_rd_d      = 1'b0;
               mem_wr_d      = 1'b0;
               ee_done_d     = 1'b1;
               timeout_err_d = 1'b1;
               state_d       = S_DONE;
               if (state_q == S_MEM_RD) begin
                  ee_rdata_d = 8'hFF;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (strobe_gone) begin
               ee_done_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any outstanding request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         op_wr_q       <= 1'b0;
         cnt_q         <= '0;
         ee_rdata_q    <= 8'hFF;
         ee_done_q     <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= 8'h00;
         mem_rd_q      <= 1'b0;
         mem_wr_q      <= 1'b0;
         dirty_q       <= 1'b0;
         write_count_q <= 16'h0000;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_wr_q       <= op_wr_d;
         cnt_q         <= cnt_d;
         ee_rdata_q    <= ee_rdata_d;
         ee_done_q     <= ee_done_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_rd_q      <= mem_rd_d;
         mem_wr_q      <= mem_wr_d;
         dirty_q       <= dirty_d;
         write_count_q <= write_count_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign ee_rdata    = ee_rdata_q;
   assign ee_done     = ee_done_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_rd      = mem_rd_q;
   assign mem_wr      = mem_wr_q;
   assign dirty       = dirty_q;
   assign write_count = write_count_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_eeprom_ram_bridge.sv
// Bench for eeprom_ram_bridge: the bench plays the save-memory bus and compares
// the bridge against a transaction-level model (address map, ack-vs-timeout
// outcome, dirty / saturating count bookkeeping).
module tb_eeprom_ram_bridge;

   localparam int ADDR_W     = 18;
   localparam int TB_BASE    = 'h100;
   localparam int TB_TIMEOUT = 8;

   logic              clk;
   logic              reset_n;
   logic [7:0]        size_mask;
   logic [7:0]        ee_addr;
   logic [7:0]        ee_wdata;
   logic              ee_read;
   logic              ee_write;
   logic [7:0]        ee_rdata;
   logic              ee_done;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_rd;
   logic              mem_wr;
   logic [7:0]        mem_rdata;
   logic              mem_ack;
   logic              dirty;
   logic              dirty_clr;
   logic [15:0]       write_count;
   logic              timeout_err;

   eeprom_ram_bridge #(
      .ADDR_W (ADDR_W),
      .BASE   (18'h00100),
      .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .size_mask  (size_mask),
      .ee_addr    (ee_addr),
      .ee_wdata   (ee_wdata),
      .ee_read    (ee_read),
      .ee_write   (ee_write),
      .ee_rdata   (ee_rdata),
      .ee_done    (ee_done),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .dirty      (dirty),
      .dirty_clr  (dirty_clr),
      .write_count(write_count),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // reference model state
   bit         m_dirty;
   int         m_wc;
   bit         m_terr;
   logic [7:0] m_rdata;
   logic [7:0] smem [int];

   function automatic int map_addr(input logic [7:0] a, input logic [7:0] m);
      return (TB_BASE + int'(a & m)) % (1 << ADDR_W);
   endfunction

   function automatic int exp_cycles(input int dly);
      return (dly < TB_TIMEOUT) ? dly + 1 : TB_TIMEOUT;
   endfunction

   task automatic model_reset();
      m_dirty = 1'b0;
      m_wc    = 0;
      m_terr  = 1'b0;
      m_rdata = 8'hFF;
   endtask

   task automatic model_access(input bit wr, input int addr, input logic [7:0] d,
                               input int dly, input bit clr, input logic [7:0] rval);
      bit acked;
      acked = (dly < TB_TIMEOUT);
      if (acked && clr) begin
         m_dirty = 1'b0;
         m_wc    = 0;
      end
      if (acked) begin
         if (wr) begin
            m_dirty    = 1'b1;
            m_wc       = (m_wc >= 65535) ? 65535 : m_wc + 1;
            smem[addr] = d;
         end else begin
            m_rdata = rval;
         end
      end else begin
         m_terr = 1'b1;
         if (!wr) m_rdata = 8'hFF;
      end
   endtask

   function automatic logic [7:0] mem_read_val(input int addr);
      if (!smem.exists(addr)) smem[addr] = 8'($urandom);
      return smem[addr];
   endfunction

   // Drives one EEPROM access starting from a negedge with the bridge idle,
   // plays the bus, and reports what it saw. Results are judged by the caller.
   task automatic do_access(input bit wr, input bit hold_rd, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] m, input int dly,
                            input bit clr, input logic [7:0] rval,
                            output int o_addr, output logic [7:0] o_wdata,
                            output int o_cyc, output logic o_done,
                            output logic o_done_drop, output logic o_req_drop);
      size_mask = m;
      ee_addr   = a;
      ee_wdata  = d;
      ee_write  = wr;
      ee_read   = !wr || hold_rd;
      @(negedge clk);
      o_addr   = int'(mem_addr);
      o_wdata  = mem_wdata;
      ee_addr  = 8'($urandom);
      ee_wdata = 8'($urandom);
      o_cyc    = 0;
      while ((wr ? mem_wr : mem_rd) && o_cyc < 40) begin
         if (o_cyc == dly) begin
            mem_ack   = 1'b1;
            mem_rdata = rval;
            dirty_clr = clr;
         end
         @(negedge clk);
         mem_ack   = 1'b0;
         dirty_clr = 1'b0;
         mem_rdata = 8'($urandom);
         o_cyc++;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      o_done = ee_done;
      if (wr) ee_write = 1'b0;
      else    ee_read  = 1'b0;
      @(negedge clk);
      o_done_drop = ee_done;
      o_req_drop  = mem_rd | mem_wr;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; ee_read = 0; ee_write = 0; mem_ack = 0; dirty_clr = 0;
      mem_rdata = 8'h00; size_mask = 8'hFF; ee_addr = 0; ee_wdata = 0;
      model_reset();
      repeat (2) @(negedge clk);
      n_total++; if (ee_rdata !== 8'hFF) $display("FAIL reset_rdata got %h want ff", ee_rdata); else n_pass++;
      n_total++; if ({ee_done, mem_rd, mem_wr, dirty, timeout_err} !== 5'b0)
         $display("FAIL reset_flags got %b want 00000", {ee_done, mem_rd, mem_wr, dirty, timeout_err}); else n_pass++;
      n_total++; if (mem_addr !== '0 || mem_wdata !== 8'h00 || write_count !== 16'h0)
         $display("FAIL reset_regs got %h/%h/%h want 0", mem_addr, mem_wdata, write_count); else n_pass++;
      reset_n = 1'b1;
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 8'h33;
      @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      n_total++; if (ee_rdata !== 8'hFF || ee_done !== 1'b0)
         $display("FAIL idle_ack got rdata %h done %b want ff 0", ee_rdata, ee_done); else n_pass++;
   endtask

   task automatic test_read();
      int a; logic [7:0] wd; int cyc; logic dn, dd, rq;
      smem[map_addr(8'h85, 8'h7F)] = 8'h5A;
      do_access(0, 0, 8'h85, 8'h00, 8'h7F, 3, 0, 8'h5A, a, wd, cyc, dn, dd, rq);
      model_access(0, map_addr(8'h85, 8'h7F), 8'h00, 3, 0, 8'h5A);
      n_total++; if (a !== 'h105) $display("FAIL read_addr got %h want 105", a); else n_pass++;
      n_total++; if (cyc !== exp_cycles(3)) $display("FAIL read_cycles got %0d want %0d", cyc, exp_cycles(3)); else n_pass++;
      n_total++; if (dn !== 1'b1 || dd !== 1'b0) $display("FAIL read_done got %b%b want 10", dn, dd); else n_pass++;
      n_total++; if (ee_rdata !== m_rdata) $display("FAIL read_data got %h want %h", ee_rdata, m_rdata); else n_pass++;
   endtask

   task automatic test_write();
      int a; logic [7:0] wd; int cyc; logic dn, dd, rq; int dly;
      dly = $urandom_range(0, 5);
      do_access(1, 0, 8'hFF, 8'hC3, 8'hFF, dly, 0, 8'h00, a, wd, cyc, dn, dd, rq);
      model_access(1, map_addr(8'hFF, 8'hFF), 8'hC3, dly, 0, 8'h00);
      n_total++; if (a !== TB_BASE + 'hFF || wd !== 8'hC3) $display("FAIL write_bus got %h/%h want %h/c3", a, wd, TB_BASE + 'hFF); else n_pass++;
      n_total++; if (cyc !== exp_cycles(dly)) $display("FAIL write_cycles got %0d want %0d", cyc, exp_cycles(dly)); else n_pass++;
      n_total++; if (dirty !== m_dirty || write_count !== 16'(m_wc))
         $display("FAIL write_dirty got %b/%0d want %b/%0d", dirty, write_count, m_dirty, m_wc); else n_pass++;
      dirty_clr = 1'b1;
      @(negedge clk);
      dirty_clr = 1'b0;
      m_dirty = 1'b0; m_wc = 0;
      n_total++; if (dirty !== 1'b0 || write_count !== 16'h0)
         $display("FAIL dirty_clr got %b/%0d want 0/0", dirty, write_count); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int a; logic [7:0] wd; int cyc; logic dn, dd, rq; logic [7:0] rv;
      do_access(1, 1, 8'h12, 8'h9E, 8'hFF, 1, 0, 8'h00, a, wd, cyc, dn, dd, rq);
      model_access(1, map_addr(8'h12, 8'hFF), 8'h9E, 1, 0, 8'h00);
      n_total++; if (a !== map_addr(8'h12, 8'hFF) || cyc !== 2)
         $display("FAIL b2b_write got %h/%0d want %h/2", a, cyc, map_addr(8'h12, 8'hFF)); else n_pass++;
      n_total++; if (dd !== 1'b0 || rq !== 1'b0) $display("FAIL b2b_gap got done %b req %b want 0 0", dd, rq); else n_pass++;
      rv = mem_read_val(map_addr(8'h12, 8'hFF));
      do_access(0, 0, 8'h12, 8'h00, 8'hFF, 0, 0, rv, a, wd, cyc, dn, dd, rq);
      model_access(0, map_addr(8'h12, 8'hFF), 8'h00, 0, 0, rv);
      n_total++; if (cyc !== 1 || ee_rdata !== 8'h9E) $display("FAIL b2b_read got %0d/%h want 1/9e", cyc, ee_rdata); else n_pass++;
   endtask

   task automatic test_timeout();
      int a; logic [7:0] wd; int cyc; logic dn, dd, rq; bit prev_dirty;
      do_access(0, 0, 8'h40, 8'h00, 8'hFF, TB_TIMEOUT - 1, 0, 8'h6C, a, wd, cyc, dn, dd, rq);
      model_access(0, map_addr(8'h40, 8'hFF), 8'h00, TB_TIMEOUT - 1, 0, 8'h6C);
      n_total++; if (ee_rdata !== 8'h6C || timeout_err !== 1'b0 || cyc !== TB_TIMEOUT)
         $display("FAIL ack_at_timeout got %h/%b/%0d want 6c/0/%0d", ee_rdata, timeout_err, cyc, TB_TIMEOUT); else n_pass++;
      prev_dirty = dirty;
      do_access(0, 0, 8'h41, 8'h00, 8'hFF, 100, 0, 8'h00, a, wd, cyc, dn, dd, rq);
      model_access(0, map_addr(8'h41, 8'hFF), 8'h00, 100, 0, 8'h00);
      n_total++; if (cyc !== TB_TIMEOUT || dn !== 1'b1) $display("FAIL timeout_len got %0d/%b want %0d/1", cyc, dn, TB_TIMEOUT); else n_pass++;
      n_total++; if (ee_rdata !== 8'hFF || timeout_err !== 1'b1 || dirty !== prev_dirty)
         $display("FAIL timeout_state got %h/%b/%b want ff/1/%b", ee_rdata, timeout_err, dirty, prev_dirty); else n_pass++;
      do_access(1, 0, 8'h42, 8'h77, 8'hFF, 100, 0, 8'h00, a, wd, cyc, dn, dd, rq);
      model_access(1, map_addr(8'h42, 8'hFF), 8'h77, 100, 0, 8'h00);
      n_total++; if (cyc !== TB_TIMEOUT || dirty !== m_dirty || write_count !== 16'(m_wc))
         $display("FAIL timeout_write got %0d/%b/%0d want %0d/%b/%0d", cyc, dirty, write_count, TB_TIMEOUT, m_dirty, m_wc); else n_pass++;
   endtask

   task automatic test_clr_collide();
      int a; logic [7:0] wd; int cyc; logic dn, dd, rq;
      do_access(1, 0, 8'h07, 8'h11, 8'h7F, 2, 0, 8'h00, a, wd, cyc, dn, dd, rq);
      model_access(1, map_addr(8'h07, 8'h7F), 8'h11, 2, 0, 8'h00);
      do_access(1, 0, 8'h08, 8'h22, 8'h7F, 1, 1, 8'h00, a, wd, cyc, dn, dd, rq);
      model_access(1, map_addr(8'h08, 8'h7F), 8'h22, 1, 1, 8'h00);
      n_total++; if (dirty !== 1'b1 || write_count !== 16'd1 || 16'(m_wc) !== 16'd1)
         $display("FAIL clr_collide got %b/%0d want 1/1", dirty, write_count); else n_pass++;
   endtask

   task automatic test_saturation();
      int a; logic [7:0] wd; int cyc; logic dn, dd, rq;
      force dut.write_count_q = 16'hFFFE;
      @(negedge clk);
      release dut.write_count_q;
      m_wc = 65534;
      for (int i = 0; i < 3; i++) begin
         do_access(1, 0, 8'(i), 8'(i + 1), 8'hFF, 0, 0, 8'h00, a, wd, cyc, dn, dd, rq);
         model_access(1, map_addr(8'(i), 8'hFF), 8'(i + 1), 0, 0, 8'h00);
         n_total++; if (write_count !== 16'(m_wc)) $display("FAIL saturate_%0d got %h want %h", i, write_count, 16'(m_wc)); else n_pass++;
      end
   endtask

   task automatic test_random();
      int a; logic [7:0] wd; int cyc; logic dn, dd, rq;
      bit wr, clr; logic [7:0] ad, dt, mk, rv; int dly, ea;
      for (int i = 0; i < 30; i++) begin
         wr  = 1'($urandom);
         ad  = 8'($urandom);
         dt  = 8'($urandom);
         mk  = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h7F;
         dly = ($urandom_range(0, 5) == 0) ? 50 : $urandom_range(0, TB_TIMEOUT);
         clr = ($urandom_range(0, 3) == 0);
         ea  = map_addr(ad, mk);
         rv  = mem_read_val(ea);
         do_access(wr, 0, ad, dt, mk, dly, clr, rv, a, wd, cyc, dn, dd, rq);
         model_access(wr, ea, dt, dly, clr, rv);
         n_total++; if (a !== ea || (wr && wd !== dt))
            $display("FAIL rnd%0d_bus got %h/%h want %h/%h", i, a, wd, ea, dt); else n_pass++;
         n_total++; if (cyc !== exp_cycles(dly) || dn !== 1'b1 || dd !== 1'b0)
            $display("FAIL rnd%0d_timing got %0d/%b/%b want %0d/1/0", i, cyc, dn, dd, exp_cycles(dly)); else n_pass++;
         n_total++; if (ee_rdata !== m_rdata || dirty !== m_dirty || write_count !== 16'(m_wc) || timeout_err !== m_terr)
            $display("FAIL rnd%0d_state got %h/%b/%0d/%b want %h/%b/%0d/%b", i, ee_rdata, dirty, write_count,
                     timeout_err, m_rdata, m_dirty, m_wc, m_terr); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      int a; logic [7:0] wd; int cyc; logic dn, dd, rq;
      size_mask = 8'hFF; ee_addr = 8'h55; ee_wdata = 8'hAA; ee_write = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_total++; if (mem_wr !== 1'b1) $display("FAIL midrst_pre got %b want 1", mem_wr); else n_pass++;
      #2 reset_n = 1'b0;
      #1;
      n_total++; if ({mem_wr, mem_rd, ee_done, dirty, timeout_err} !== 5'b0 || ee_rdata !== 8'hFF || write_count !== 16'h0 || mem_addr !== '0)
         $display("FAIL midrst_async got %b/%h/%h/%h want 00000/ff/0/0", {mem_wr, mem_rd, ee_done, dirty, timeout_err},
                  ee_rdata, write_count, mem_addr); else n_pass++;
      ee_write = 1'b0;
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      do_access(1, 0, 8'h55, 8'hAA, 8'hFF, 2, 0, 8'h00, a, wd, cyc, dn, dd, rq);
      model_access(1, map_addr(8'h55, 8'hFF), 8'hAA, 2, 0, 8'h00);
      n_total++; if (a !== map_addr(8'h55, 8'hFF) || cyc !== 3 || dirty !== m_dirty || write_count !== 16'(m_wc))
         $display("FAIL midrst_after got %h/%0d/%b/%0d want %h/3/%b/%0d", a, cyc, dirty, write_count,
                  map_addr(8'h55, 8'hFF), m_dirty, m_wc); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_timeout();
      test_clr_collide();
      test_saturation();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
